// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin front end sharing one iterative divider core
module div_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [32*NUM_REQ-1:0]  req_op1_i,
  input  logic [32*NUM_REQ-1:0]  req_op2_i,
  input  logic [2*NUM_REQ-1:0]   req_op_i,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  input  logic [NUM_REQ-1:0]     rsp_ready_i,
  output logic [31:0]            rsp_data_o,
  output logic                   rsp_err_o,
  output logic                   div_start_o,
  output logic [31:0]            div_dividend_o,
  output logic [31:0]            div_divisor_o,
  input  logic                   div_valid_i,
  input  logic [31:0]            div_quotient_i,
  input  logic [31:0]            div_remainder_i
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_REM  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] grant_q;
  logic [1:0]       op_q;
  logic             op1_neg_q;
  logic             op2_neg_q;
  logic [31:0]      dividend_q;
  logic [31:0]      divisor_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      data_q;
  logic             err_q;

  logic [31:0] op1_arr [NUM_REQ];
  logic [31:0] op2_arr [NUM_REQ];
  logic [1:0]  op_arr  [NUM_REQ];

  logic             found;
  logic [IDX_W-1:0] grant_idx;

  logic [31:0] sel_op1;
  logic [31:0] sel_op2;
  logic [1:0]  sel_op;
  logic        sel_signed;
  logic        sel_rem;
  logic        div_by_zero;
  logic        sgn_ovf;
  logic        bypass;
  logic [31:0] bypass_data;
  logic [31:0] mag1;
  logic [31:0] mag2;

  logic [31:0] core_sel;
  logic        core_neg;
  logic [31:0] core_data;

  logic accept;
  logic core_done;
  logic timeout_hit;
  logic rsp_done;

  // Index 'off' positions after 'base', wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Split the packed request buses into per-requester fields.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      op1_arr[k] = req_op1_i[32*k +: 32];
      op2_arr[k] = req_op2_i[32*k +: 32];
      op_arr[k]  = req_op_i[2*k +: 2];
    end
  end

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req_valid_i[rr_idx(ptr_q, i)]) begin
        found     = 1'b1;
        grant_idx = rr_idx(ptr_q, i);
      end
    end
  end

  // Decode the granted request: special cases and operand magnitudes.
  always_comb begin
    sel_op1     = op1_arr[grant_idx];
    sel_op2     = op2_arr[grant_idx];
    sel_op      = op_arr[grant_idx];
    sel_signed  = ~sel_op[0];
    sel_rem     = sel_op[1];
    div_by_zero = (sel_op2 == 32'h0);
    sgn_ovf     = sel_signed && (sel_op1 == 32'h8000_0000) && (sel_op2 == 32'hFFFF_FFFF);
    bypass      = div_by_zero || sgn_ovf;
    if (div_by_zero) begin
      bypass_data = sel_rem ? sel_op1 : 32'hFFFF_FFFF;
    end else begin
      bypass_data = sel_rem ? 32'h0 : 32'h8000_0000;
    end
    mag1 = (sel_signed && sel_op1[31]) ? (~sel_op1 + 32'd1) : sel_op1;
    mag2 = (sel_signed && sel_op2[31]) ? (~sel_op2 + 32'd1) : sel_op2;
  end

  // Pick quotient or remainder from the core and restore the sign.
  always_comb begin
    core_sel = op_q[1] ? div_remainder_i : div_quotient_i;
    case (op_q)
      OP_DIV:  core_neg = op1_neg_q ^ op2_neg_q;
      OP_REM:  core_neg = op1_neg_q;
      default: core_neg = 1'b0;
    endcase
    core_data = core_neg ? (~core_sel + 32'd1) : core_sel;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake/strobe outputs.
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    div_start_o = 1'b0;
    accept      = 1'b0;
    core_done   = 1'b0;
    timeout_hit = 1'b0;
    rsp_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rst_ni && found) begin
          req_ready_o[grant_idx] = 1'b1;
          accept                 = 1'b1;
          state_d                = bypass ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_start_o = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (div_valid_i) begin
          core_done = 1'b1;
          state_d   = S_RESP;
        end else if (cnt_q == CNT_MAX) begin
          timeout_hit = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid_o[grant_q] = 1'b1;
        if (rsp_ready_i[grant_q]) begin
          rsp_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture and round-robin pointer update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      grant_q    <= '0;
      op_q       <= 2'b00;
      op1_neg_q  <= 1'b0;
      op2_neg_q  <= 1'b0;
      dividend_q <= 32'h0;
      divisor_q  <= 32'h0;
    end else if (accept) begin
      ptr_q      <= grant_idx;
      grant_q    <= grant_idx;
      op_q       <= sel_op;
      op1_neg_q  <= sel_signed & sel_op1[31];
      op2_neg_q  <= sel_signed & sel_op2[31];
      dividend_q <= mag1;
      divisor_q  <= mag2;
    end
  end

  // WAIT watchdog: cleared while issuing, counts every WAIT cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (state_q == S_ISSUE) begin
      cnt_q <= '0;
    end else if (state_q == S_WAIT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Response payload: bypass result, core result or timeout abort.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= 32'h0;
      err_q  <= 1'b0;
    end else begin
      if (accept && bypass) begin
        data_q <= bypass_data;
        err_q  <= 1'b0;
      end
      if (core_done) begin
        data_q <= core_data;
        err_q  <= 1'b0;
      end
      if (timeout_hit) begin
        data_q <= 32'h0;
        err_q  <= 1'b1;
      end
      if (rsp_done) begin
        err_q <= 1'b0;
      end
    end
  end

  assign div_dividend_o = dividend_q;
  assign div_divisor_o  = divisor_q;
  assign rsp_data_o     = data_q;
  assign rsp_err_o      = err_q;

endmodule
